// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: H/V timing generator plus test-pattern engine for RGB
// parallel LCD panels, with a fully registered output stage.
//
// Ports:
//   i_lcd_pclk    pixel clock (sole clock)
//   i_rst_n       asynchronous active-low reset
//   i_en          run enable; low holds counters at 0 and idles the outputs
//   i_mode        pattern: 0 colorbar, 1 gray ramp, 2 checkerboard, 3 border
//   i_fg_color    foreground colour {R,G,B} for checkerboard and border
//   o_lcd_de      data enable
//   o_lcd_hs      horizontal sync, active low
//   o_lcd_vs      vertical sync, active low
//   o_lcd_rgb     pixel {R,G,B}, zero whenever DE is low
//   o_pixel_xpos  active X of the output pixel, 0 outside the active area
//   o_pixel_ypos  active Y of the output pixel, 0 outside the active area
//   o_frame_start one-cycle pulse on the first pixel period of each frame
module lcd_pattern_gen #(
  parameter int P_H_SYNC   = 128,
  parameter int P_H_BACK   = 88,
  parameter int P_H_DISP   = 800,
  parameter int P_H_FRONT  = 40,
  parameter int P_V_SYNC   = 2,
  parameter int P_V_BACK   = 33,
  parameter int P_V_DISP   = 480,
  parameter int P_V_FRONT  = 10,
  parameter int P_CNT_W    = 11,
  parameter int P_CH_W     = 8,
  parameter int P_BAR_NUM  = 8,
  parameter int P_CHK_LOG2 = 5
) (
  input  logic                  i_lcd_pclk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [3*P_CH_W-1:0]   i_fg_color,
  output logic                  o_lcd_de,
  output logic                  o_lcd_hs,
  output logic                  o_lcd_vs,
  output logic [3*P_CH_W-1:0]   o_lcd_rgb,
  output logic [P_CNT_W-1:0]    o_pixel_xpos,
  output logic [P_CNT_W-1:0]    o_pixel_ypos,
  output logic                  o_frame_start
);

  localparam int H_TOTAL = P_H_SYNC + P_H_BACK + P_H_DISP + P_H_FRONT;
  localparam int V_TOTAL = P_V_SYNC + P_V_BACK + P_V_DISP + P_V_FRONT;
  localparam int ACC_W   = P_CH_W + 16;
  localparam int BAR_W   = P_H_DISP / P_BAR_NUM;

  localparam logic [P_CNT_W-1:0] H_LAST     = P_CNT_W'(H_TOTAL - 1);
  localparam logic [P_CNT_W-1:0] V_LAST     = P_CNT_W'(V_TOTAL - 1);
  localparam logic [P_CNT_W-1:0] H_SYNC_C   = P_CNT_W'(P_H_SYNC);
  localparam logic [P_CNT_W-1:0] V_SYNC_C   = P_CNT_W'(P_V_SYNC);
  localparam logic [P_CNT_W-1:0] H_ACT_C    = P_CNT_W'(P_H_SYNC + P_H_BACK);
  localparam logic [P_CNT_W-1:0] V_ACT_C    = P_CNT_W'(P_V_SYNC + P_V_BACK);
  localparam logic [P_CNT_W-1:0] H_END_C    = P_CNT_W'(P_H_SYNC + P_H_BACK + P_H_DISP);
  localparam logic [P_CNT_W-1:0] V_END_C    = P_CNT_W'(P_V_SYNC + P_V_BACK + P_V_DISP);
  localparam logic [P_CNT_W-1:0] H_DISP_M1  = P_CNT_W'(P_H_DISP - 1);
  localparam logic [P_CNT_W-1:0] V_DISP_M1  = P_CNT_W'(P_V_DISP - 1);
  localparam logic [P_CNT_W-1:0] BAR_W_M1   = P_CNT_W'(BAR_W - 1);
  localparam logic [P_CNT_W-1:0] BAR_LAST   = P_CNT_W'(P_BAR_NUM - 1);
  localparam logic [ACC_W-1:0]   STEP       = ACC_W'((64'd1 << ACC_W) / P_H_DISP);

  // Fixed eight-colour palette; each channel is all-ones or all-zeros.
  function automatic logic [3*P_CH_W-1:0] palette(input logic [2:0] idx);
    logic [2:0] bits;
    case (idx)
      3'd0:    bits = 3'b111; // white
      3'd1:    bits = 3'b110; // yellow
      3'd2:    bits = 3'b011; // cyan
      3'd3:    bits = 3'b010; // green
      3'd4:    bits = 3'b101; // magenta
      3'd5:    bits = 3'b100; // red
      3'd6:    bits = 3'b001; // blue
      default: bits = 3'b000; // black
    endcase
    return {{P_CH_W{bits[2]}}, {P_CH_W{bits[1]}}, {P_CH_W{bits[0]}}};
  endfunction

  logic [P_CNT_W-1:0]  h_cnt_r, v_cnt_r, h_nxt_s, v_nxt_s;
  logic [P_CNT_W-1:0]  bar_cnt_r, bar_idx_r, bar_cnt_s, bar_idx_s;
  logic [P_CNT_W-1:0]  bar_cnt_nxt_s, bar_idx_nxt_s;
  logic [ACC_W-1:0]    acc_r, acc_s;
  logic [1:0]          mode_r;
  logic [P_CNT_W-1:0]  x_s, y_s;
  logic                active_s, line_first_s, frame_first_s, border_s;
  logic [3*P_CH_W-1:0] pix_s;

  // Next H/V counter values with line and frame wrap.
  always_comb begin
    h_nxt_s = h_cnt_r + P_CNT_W'(1);
    v_nxt_s = v_cnt_r;
    if (h_cnt_r == H_LAST) begin
      h_nxt_s = '0;
      if (v_cnt_r == V_LAST) begin
        v_nxt_s = '0;
      end else begin
        v_nxt_s = v_cnt_r + P_CNT_W'(1);
      end
    end else begin
      h_nxt_s = h_cnt_r + P_CNT_W'(1);
    end
  end

  // H/V counters; held at 0 while disabled so a re-enable restarts the frame.
  always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (!i_en) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else begin
      h_cnt_r <= h_nxt_s;
      v_cnt_r <= v_nxt_s;
    end
  end

  // Window decode, active coordinates and per-pixel bar/ramp state.
  // The bar and ramp registers hold the value for the current pixel except at
  // the first active pixel of a line, where the state is forced to zero.
  always_comb begin
    active_s      = (h_cnt_r >= H_ACT_C) && (h_cnt_r < H_END_C) &&
                    (v_cnt_r >= V_ACT_C) && (v_cnt_r < V_END_C);
    line_first_s  = (h_cnt_r == H_ACT_C);
    frame_first_s = (h_cnt_r == '0) && (v_cnt_r == '0);
    x_s           = h_cnt_r - H_ACT_C;
    y_s           = v_cnt_r - V_ACT_C;
    border_s      = (x_s == '0) || (x_s == H_DISP_M1) ||
                    (y_s == '0) || (y_s == V_DISP_M1);
    if (line_first_s) begin
      bar_cnt_s = '0;
      bar_idx_s = '0;
      acc_s     = '0;
    end else begin
      bar_cnt_s = bar_cnt_r;
      bar_idx_s = bar_idx_r;
      acc_s     = acc_r;
    end
    // The last bar never rolls over, so it absorbs the remainder pixels.
    if ((bar_cnt_s == BAR_W_M1) && (bar_idx_s != BAR_LAST)) begin
      bar_cnt_nxt_s = '0;
      bar_idx_nxt_s = bar_idx_s + P_CNT_W'(1);
    end else begin
      bar_cnt_nxt_s = bar_cnt_s + P_CNT_W'(1);
      bar_idx_nxt_s = bar_idx_s;
    end
  end

  // Bar/ramp state advances only on active pixels; mode latches at frame start.
  always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bar_cnt_r <= '0;
      bar_idx_r <= '0;
      acc_r     <= '0;
      mode_r    <= 2'd0;
    end else if (!i_en) begin
      bar_cnt_r <= '0;
      bar_idx_r <= '0;
      acc_r     <= '0;
      mode_r    <= mode_r;
    end else begin
      if (active_s) begin
        bar_cnt_r <= bar_cnt_nxt_s;
        bar_idx_r <= bar_idx_nxt_s;
        acc_r     <= acc_s + STEP;
      end else begin
        bar_cnt_r <= bar_cnt_r;
        bar_idx_r <= bar_idx_r;
        acc_r     <= acc_r;
      end
      if (frame_first_s) begin
        mode_r <= i_mode;
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  // Pattern engine.
  always_comb begin
    pix_s = '0;
    case (mode_r)
      2'd0:    pix_s = palette(bar_idx_s[2:0]);
      2'd1:    pix_s = {3{acc_s[ACC_W-1:16]}};
      2'd2: begin
        if ((x_s[P_CHK_LOG2] ^ y_s[P_CHK_LOG2]) == 1'b0) begin
          pix_s = i_fg_color;
        end else begin
          pix_s = '0;
        end
      end
      2'd3: begin
        if (border_s) begin
          pix_s = '1;
        end else begin
          pix_s = i_fg_color;
        end
      end
      default: pix_s = '0;
    endcase
  end

  // Output stage: every panel-facing signal registered from the same (h,v).
  always_ff @(posedge i_lcd_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lcd_de      <= 1'b0;
      o_lcd_hs      <= 1'b1;
      o_lcd_vs      <= 1'b1;
      o_lcd_rgb     <= '0;
      o_pixel_xpos  <= '0;
      o_pixel_ypos  <= '0;
      o_frame_start <= 1'b0;
    end else if (!i_en) begin
      o_lcd_de      <= 1'b0;
      o_lcd_hs      <= 1'b1;
      o_lcd_vs      <= 1'b1;
      o_lcd_rgb     <= '0;
      o_pixel_xpos  <= '0;
      o_pixel_ypos  <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_lcd_de      <= active_s;
      o_lcd_hs      <= (h_cnt_r >= H_SYNC_C);
      o_lcd_vs      <= (v_cnt_r >= V_SYNC_C);
      o_lcd_rgb     <= active_s ? pix_s : '0;
      o_pixel_xpos  <= active_s ? x_s : '0;
      o_pixel_ypos  <= active_s ? y_s : '0;
      o_frame_start <= frame_first_s;
    end
  end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Testbench for lcd_pattern_gen on a small 22x7 raster (16x4 active).
module tb_lcd_pattern_gen;

  localparam int HT = 22;
  localparam int VT = 7;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic [23:0] rgb;
  } out_t;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] fg;
    int          row;
    int          x;
    logic [23:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] fg;
  logic        de_o, hs_o, vs_o, fs_o;
  logic [23:0] rgb_o;
  logic [10:0] xpos_o, ypos_o;

  int total = 0;
  int bad = 0;

  // model state: counter values the DUT will hold after the next edge
  int mh, mv;
  logic [1:0] mode_m;
  logic       cur_en;
  logic [1:0] cur_mode;
  logic [23:0] cur_fg;
  out_t sb[$];
  out_t last_obs;
  logic [23:0] cap [4][16];
  int n_de, n_hs_lo, n_vs_lo, n_fs;

  always #5 clk = ~clk;

  lcd_pattern_gen #(
    .P_H_SYNC(2), .P_H_BACK(2), .P_H_DISP(16), .P_H_FRONT(2),
    .P_V_SYNC(1), .P_V_BACK(1), .P_V_DISP(4), .P_V_FRONT(1),
    .P_CNT_W(11), .P_CH_W(8), .P_BAR_NUM(4), .P_CHK_LOG2(2)
  ) dut (
    .i_lcd_pclk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode),
    .i_fg_color(fg), .o_lcd_de(de_o), .o_lcd_hs(hs_o), .o_lcd_vs(vs_o),
    .o_lcd_rgb(rgb_o), .o_pixel_xpos(xpos_o), .o_pixel_ypos(ypos_o),
    .o_frame_start(fs_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic out_t idle_o();
    out_t o;
    o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  function automatic logic [23:0] ref_pix(input int x, input int y,
                                          input logic [1:0] md, input logic [23:0] fgv);
    int bar;
    int g;
    logic [7:0] g8;
    case (md)
      2'd0: begin
        bar = x / (16 / 4);
        if (bar > 3) bar = 3;
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          default: return 24'h00FF00;
        endcase
      end
      2'd1: begin
        g  = (x * ((1 << 24) / 16)) >> 16;
        g8 = g[7:0];
        return {g8, g8, g8};
      end
      2'd2: return ((((x >> 2) & 1) ^ ((y >> 2) & 1)) == 0) ? fgv : 24'h000000;
      default: return (x == 0 || x == 15 || y == 0 || y == 3) ? 24'hFFFFFF : fgv;
    endcase
  endfunction

  function automatic out_t model_out(input logic en_v, input logic [1:0] mode_v,
                                     input logic [23:0] fg_v);
    out_t o;
    logic [1:0] md;
    logic act;
    o = idle_o();
    if (en_v) begin
      md   = (mh == 0 && mv == 0) ? mode_v : mode_m;
      act  = (mh >= 4 && mh < 20 && mv >= 2 && mv < 6);
      o.de = act;
      o.hs = !(mh < 2);
      o.vs = !(mv < 1);
      o.fs = (mh == 0 && mv == 0);
      if (act) begin
        o.xpos = 11'(mh - 4);
        o.ypos = 11'(mv - 2);
        o.rgb  = ref_pix(mh - 4, mv - 2, md, fg_v);
      end
    end
    return o;
  endfunction

  task automatic drive_and_push();
    en   = cur_en;
    mode = cur_mode;
    fg   = cur_fg;
    sb.push_back(model_out(cur_en, cur_mode, cur_fg));
    if (cur_en) begin
      if (mh == 0 && mv == 0) mode_m = cur_mode;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end else begin
      mh = 0;
      mv = 0;
    end
  endtask

  task automatic tick();
    out_t a, e;
    @(negedge clk);
    a = {de_o, hs_o, vs_o, fs_o, xpos_o, ypos_o, rgb_o};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("cycle", 64'(a), 64'(e));
    end
    last_obs = a;
    if (a.de && a.xpos < 16 && a.ypos < 4) cap[a.ypos][a.xpos] = a.rgb;
    n_de    += int'(a.de);
    n_hs_lo += int'(!a.hs);
    n_vs_lo += int'(!a.vs);
    n_fs    += int'(a.fs);
    drive_and_push();
  endtask

  task automatic do_reset();
    out_t a;
    rst_n = 1'b0;
    sb.delete();
    mh = 0;
    mv = 0;
    mode_m = 2'd0;
    en = cur_en;
    mode = cur_mode;
    fg = cur_fg;
    repeat (2) @(negedge clk);
    a = {de_o, hs_o, vs_o, fs_o, xpos_o, ypos_o, rgb_o};
    chk("reset_idle", 64'(a), 64'(idle_o()));
    rst_n = 1'b1;
    drive_and_push();
  endtask

  task automatic seek(input int hv, input int vv);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (mh == hv && mv == vv) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("seek", 64'(found), 64'd1);
  endtask

  task automatic wait_fs();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (last_obs.fs) begin
        found = 1'b1;
        break;
      end
    end
    chk("wait_fs", 64'(found), 64'd1);
  endtask

  vec_t vecs [$];

  initial begin
    out_t a;
    logic first;
    vecs = '{
      '{2'd0, 24'h000000, 0, 0,  24'hFFFFFF},
      '{2'd0, 24'h000000, 0, 3,  24'hFFFFFF},
      '{2'd0, 24'h000000, 0, 4,  24'hFFFF00},
      '{2'd0, 24'h000000, 1, 8,  24'h00FFFF},
      '{2'd0, 24'h000000, 2, 12, 24'h00FF00},
      '{2'd0, 24'h000000, 3, 15, 24'h00FF00},
      '{2'd1, 24'h000000, 0, 0,  24'h000000},
      '{2'd1, 24'h000000, 0, 1,  24'h101010},
      '{2'd1, 24'h000000, 2, 8,  24'h808080},
      '{2'd1, 24'h000000, 3, 15, 24'hF0F0F0},
      '{2'd2, 24'h123456, 0, 0,  24'h123456},
      '{2'd2, 24'h123456, 1, 4,  24'h000000},
      '{2'd2, 24'h123456, 3, 7,  24'h000000},
      '{2'd2, 24'h123456, 2, 9,  24'h123456},
      '{2'd2, 24'h123456, 2, 12, 24'h000000},
      '{2'd3, 24'h0000FF, 0, 7,  24'hFFFFFF},
      '{2'd3, 24'h0000FF, 3, 5,  24'hFFFFFF},
      '{2'd3, 24'h0000FF, 1, 0,  24'hFFFFFF},
      '{2'd3, 24'h0000FF, 2, 15, 24'hFFFFFF},
      '{2'd3, 24'h0000FF, 1, 7,  24'h0000FF},
      '{2'd3, 24'h0000FF, 2, 14, 24'h0000FF}
    };
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 16; c++)
        cap[r][c] = 24'hDEADBE;
    n_de = 0; n_hs_lo = 0; n_vs_lo = 0; n_fs = 0;
    cur_en = 1'b1;
    cur_mode = 2'd0;
    cur_fg = 24'h000000;
    do_reset();

    // first frame_start one cycle after reset release
    tick();
    chk("first_fs", 64'(last_obs.fs), 64'd1);

    // one full frame period of sync/enable statistics
    n_de = 0; n_hs_lo = 0; n_vs_lo = 0; n_fs = 0;
    repeat (FRAME) tick();
    chk("frame_de_cnt", 64'(n_de), 64'd64);
    chk("frame_hs_lo", 64'(n_hs_lo), 64'd14);
    chk("frame_vs_lo", 64'(n_vs_lo), 64'd22);
    chk("frame_fs_cnt", 64'(n_fs), 64'd1);
    chk("frame_period", 64'(last_obs.fs), 64'd1);

    // table of pattern pixels
    first = 1'b1;
    foreach (vecs[i]) begin
      if (first || vecs[i].mode != cur_mode || vecs[i].fg != cur_fg) begin
        cur_mode = vecs[i].mode;
        cur_fg   = vecs[i].fg;
        repeat (2 * FRAME + 4) tick();
        first = 1'b0;
      end
      chk($sformatf("pix_m%0d_r%0d_x%0d", vecs[i].mode, vecs[i].row, vecs[i].x),
          64'(cap[vecs[i].row][vecs[i].x]), 64'(vecs[i].exp));
    end

    // mode 0 -> 2 switched at active line 2: takes effect at the next frame
    cur_mode = 2'd0;
    cur_fg = 24'h123456;
    repeat (2 * FRAME + 4) tick();
    seek(0, 4);
    cur_mode = 2'd2;
    wait_fs();
    chk("switch_old_r2x4", 64'(cap[2][4]), 64'hFFFF00);
    chk("switch_old_r3x0", 64'(cap[3][0]), 64'hFFFFFF);
    repeat (FRAME) tick();
    chk("switch_new_r2x4", 64'(cap[2][4]), 64'h000000);
    chk("switch_new_r3x0", 64'(cap[3][0]), 64'h123456);

    // enable dropped mid-line for 5 cycles
    seek(14, 3);
    cur_en = 1'b0;
    repeat (5) tick();
    chk("en_idle_de", 64'(last_obs.de), 64'd0);
    chk("en_idle_hs", 64'(last_obs.hs), 64'd1);
    chk("en_idle_rgb", 64'(last_obs.rgb), 64'd0);
    cur_en = 1'b1;
    tick();
    tick();
    chk("restart_fs", 64'(last_obs.fs), 64'd1);
    chk("restart_hs", 64'(last_obs.hs), 64'd0);
    chk("restart_vs", 64'(last_obs.vs), 64'd0);
    repeat (FRAME + 10) tick();

    // asynchronous reset in the middle of an active line
    seek(10, 4);
    #2 rst_n = 1'b0;
    #1;
    a = {de_o, hs_o, vs_o, fs_o, xpos_o, ypos_o, rgb_o};
    chk("async_reset", 64'(a), 64'(idle_o()));
    cur_mode = 2'd1;
    do_reset();
    tick();
    chk("rerun_fs", 64'(last_obs.fs), 64'd1);
    repeat (2 * FRAME) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
